// File: rtl/dsm_pkg.sv
// Shared constants for the delta-sigma modulator: ternary pwm codes, dither LFSR
// polynomial/seed and default sample-path sizing.
package dsm_pkg;

  localparam int unsigned DEF_IN_W = 15;
  localparam int unsigned DEF_OSR  = 8;

  // Ternary output code; 2'b10 is never produced.
  typedef enum logic [1:0] {
    PWM_ZERO = 2'b00,
    PWM_POS  = 2'b01,
    PWM_NEG  = 2'b11
  } pwm_e;

  // Galois right-shift form of x^16 + x^14 + x^13 + x^11 + 1 (maximal length).
  localparam int unsigned    LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/dsm_mod_gen_if.sv
// Sample-input handshake: the producer (master) offers vin with in_valid,
// the modulator (slave) returns a registered in_ready.
interface dsm_mod_gen_if
  import dsm_pkg::*;
#(
  parameter int unsigned IN_W = DEF_IN_W
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic signed [IN_W-1:0] vin;

  modport master (output in_valid, output vin, input in_ready);
  modport slave  (input in_valid, input vin, output in_ready);

endinterface

// File: rtl/dsm_lfsr.sv
// 16-bit maximal-length Galois LFSR used as quantiser dither; steps only when enabled.
module dsm_lfsr
  import dsm_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_en,
  output logic [LFSR_W-1:0] o_state
);

  logic [LFSR_W-1:0] r_state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= LFSR_SEED;
    end else if (i_en) begin
      r_state <= r_state[0] ? ((r_state >> 1) ^ LFSR_TAPS) : (r_state >> 1);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/dsm_mod_gen.sv
// First/second-order ternary delta-sigma modulator with a 1-deep sample buffer,
// zero-order hold on starvation and clamping integrators. Optional dither: DSM_DITHER_EN.
module dsm_mod_gen
  import dsm_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned OSR   = DEF_OSR,
  parameter int unsigned ORDER = 1,
  parameter int unsigned ACC_W = IN_W + 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic          clr_flags,
  dsm_mod_gen_if.slave  s_in,
  output logic [1:0]    pwm,
  output logic          sat,
  output logic          underrun
);

  // Headroom so v, v+dither and i+cur-y*FS never wrap before clamping.
  localparam int unsigned EXT_W = ACC_W + 3;
  localparam int unsigned PH_W  = (OSR > 1) ? $clog2(OSR) : 1;

  localparam logic [PH_W-1:0]         PH_MAX    = PH_W'(OSR - 1);
  localparam logic signed [EXT_W-1:0] FS_X      = EXT_W'(1) << (IN_W - 1);
  localparam logic signed [EXT_W-1:0] NFS_X     = -FS_X;
  localparam logic signed [EXT_W-1:0] T_X       = FS_X >>> 1;
  localparam logic signed [EXT_W-1:0] NT_X      = -T_X;
  localparam logic signed [EXT_W-1:0] BOUND_X   = (EXT_W'(1) << (ACC_W - 1)) - EXT_W'(1);
  localparam logic signed [EXT_W-1:0] NBOUND_X  = -BOUND_X;

  function automatic logic f_ovf(input logic signed [EXT_W-1:0] x);
    return (x > BOUND_X) || (x < NBOUND_X);
  endfunction

  function automatic logic signed [ACC_W-1:0] f_clamp(input logic signed [EXT_W-1:0] x);
    logic signed [EXT_W-1:0] c;
    c = (x > BOUND_X) ? BOUND_X : ((x < NBOUND_X) ? NBOUND_X : x);
    return ACC_W'(c);
  endfunction

  logic [PH_W-1:0]         r_phase;
  logic                    r_buf_full;
  logic signed [IN_W-1:0]  r_buf;
  logic signed [IN_W-1:0]  r_cur;
  logic signed [ACC_W-1:0] r_i1;
  logic signed [ACC_W-1:0] r_i2;
  pwm_e                    r_pwm;
  logic                    r_in_ready;
  logic                    r_sat;
  logic                    r_underrun;

  logic                    w_accept;
  logic                    w_load;
  logic                    w_buf_full_nxt;
  logic                    w_underrun_set;
  logic                    w_sat_set;
  logic signed [EXT_W-1:0] w_cur_x;
  logic signed [EXT_W-1:0] w_i1_x;
  logic signed [EXT_W-1:0] w_i2_x;
  logic signed [EXT_W-1:0] w_dith_x;
  logic signed [EXT_W-1:0] w_v;
  logic signed [EXT_W-1:0] w_vq;
  logic signed [EXT_W-1:0] w_yfs;
  logic signed [EXT_W-1:0] w_n1;
  logic signed [EXT_W-1:0] w_n2;
  pwm_e                    w_y;

`ifdef DSM_DITHER_EN
  logic [LFSR_W-1:0] w_lfsr;

  dsm_lfsr u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .i_en    (en),
    .o_state (w_lfsr)
  );

  assign w_dith_x = EXT_W'($signed(w_lfsr[LFSR_W-1 -: 4]));
`else
  assign w_dith_x = '0;
`endif

  assign w_cur_x = EXT_W'(r_cur);
  assign w_i1_x  = EXT_W'(r_i1);
  assign w_i2_x  = EXT_W'(r_i2);

  // Handshake, load scheduling, quantiser and integrator next-values.
  always_comb begin
    w_accept       = 1'b0;
    w_load         = 1'b0;
    w_buf_full_nxt = r_buf_full;
    w_underrun_set = 1'b0;
    w_sat_set      = 1'b0;
    w_v            = '0;
    w_vq           = '0;
    w_yfs          = '0;
    w_n1           = '0;
    w_n2           = '0;
    w_y            = PWM_ZERO;

    w_accept       = s_in.in_valid & r_in_ready;
    w_load         = en & (r_phase == PH_MAX);
    w_buf_full_nxt = w_load ? 1'b0 : (r_buf_full | w_accept);
    w_underrun_set = w_load & ~r_buf_full & ~w_accept;

    w_v  = ((ORDER == 2) ? w_i2_x : w_i1_x) + w_cur_x;
    w_vq = w_v + w_dith_x;
    if (w_vq >= T_X) begin
      w_y = PWM_POS;
    end else if (w_vq < NT_X) begin
      w_y = PWM_NEG;
    end

    if (w_y == PWM_POS) begin
      w_yfs = FS_X;
    end else if (w_y == PWM_NEG) begin
      w_yfs = NFS_X;
    end

    // Dither only steers the decision; feedback uses the undithered v.
    w_n1 = (ORDER == 2) ? (w_i1_x + w_cur_x - w_yfs) : (w_v - w_yfs);
    w_n2 = w_i2_x + w_i1_x - w_yfs;
    w_sat_set = en & (f_ovf(w_n1) | ((ORDER == 2) & f_ovf(w_n2)));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_phase    <= '0;
      r_buf_full <= 1'b0;
      r_buf      <= '0;
      r_cur      <= '0;
      r_i1       <= '0;
      r_i2       <= '0;
      r_pwm      <= PWM_ZERO;
      r_in_ready <= 1'b0;
      r_sat      <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_in_ready <= ~w_buf_full_nxt;
      r_buf_full <= w_buf_full_nxt;

      // Load takes the buffer, else bypasses a same-cycle accept, else holds cur.
      if (w_load) begin
        if (r_buf_full) begin
          r_cur <= r_buf;
        end else if (w_accept) begin
          r_cur <= s_in.vin;
        end
      end else if (w_accept) begin
        r_buf <= s_in.vin;
      end

      if (en) begin
        r_phase <= w_load ? '0 : (r_phase + PH_W'(1));
        r_i1    <= f_clamp(w_n1);
        if (ORDER == 2) begin
          r_i2 <= f_clamp(w_n2);
        end
        r_pwm   <= w_y;
      end else begin
        r_pwm   <= PWM_ZERO;
      end

      r_sat      <= w_sat_set | (r_sat & ~clr_flags);
      r_underrun <= w_underrun_set | (r_underrun & ~clr_flags);
    end
  end

  assign s_in.in_ready = r_in_ready;
  assign pwm           = r_pwm;
  assign sat           = r_sat;
  assign underrun      = r_underrun;

endmodule

// File: tb/tb_dsm_mod_gen.sv
// Bench for dsm_mod_gen: DC-input code-count table, handshake/starvation/overflow/reset
// sequences and random traffic, all checked every clock against an integer model.
module tb_dsm_mod_gen;

  localparam int OSR = 8;
  localparam int FS  = 16384;
  localparam int T   = 8192;
  localparam int B1  = 262143;
  localparam int B2  = 32767;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic clr_flags = 1'b0;
  logic [1:0] pwm1, pwm2;
  logic sat1, sat2, und1, und2;

  dsm_mod_gen_if #(.IN_W(15)) if1 ();
  dsm_mod_gen_if #(.IN_W(15)) if2 ();

  dsm_mod_gen u_dut1 (
    .clock(clock), .reset(reset), .en(en), .clr_flags(clr_flags),
    .s_in(if1), .pwm(pwm1), .sat(sat1), .underrun(und1)
  );

  dsm_mod_gen #(.ORDER(2), .ACC_W(16)) u_dut2 (
    .clock(clock), .reset(reset), .en(en), .clr_flags(clr_flags),
    .s_in(if2), .pwm(pwm2), .sat(sat2), .underrun(und2)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int sel = 0;
  bit last_acc;

  // Behavioural model: buffer as a queue, integrators as plain integers.
  int m_q[$];
  bit m_rdy, m_sat, m_und;
  int m_phase, m_cur, m_i1, m_i2, m_y;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d sel=%0d: got %0d expected %0d", nm, cyc, sel,
               $signed(act), $signed(exp));
    end
  endtask

  function automatic int code(input int y);
    return (y > 0) ? 1 : ((y < 0) ? 3 : 0);
  endfunction

  function automatic int clip(input int x, input int b);
    return (x > b) ? b : ((x < -b) ? -b : x);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_rdy = 0; m_sat = 0; m_und = 0;
    m_phase = 0; m_cur = 0; m_i1 = 0; m_i2 = 0; m_y = 0;
  endtask

  task automatic model_step(input bit e, input bit iv, input bit clr, input int x);
    bit acc, ld, s_set, u_set;
    int v, y, yfs, a, b, bnd;
    bnd = (sel != 0) ? B2 : B1;
    acc = iv && m_rdy;
    ld = e && (m_phase == OSR - 1);
    s_set = 0; u_set = 0;
    if (e) begin
      v = ((sel != 0) ? m_i2 : m_i1) + m_cur;
      y = (v >= T) ? 1 : ((v < -T) ? -1 : 0);
      yfs = y * FS;
      if (sel != 0) begin
        a = m_i1 + m_cur - yfs;
        b = m_i2 + m_i1 - yfs;
      end else begin
        a = v - yfs;
        b = 0;
      end
      if (a > bnd || a < -bnd || b > bnd || b < -bnd) s_set = 1;
      m_i1 = clip(a, bnd);
      m_i2 = clip(b, bnd);
      m_y = y;
      m_phase = (m_phase + 1) % OSR;
    end else begin
      m_y = 0;
    end
    if (ld) begin
      if (m_q.size() > 0) m_cur = m_q.pop_front();
      else if (acc) m_cur = x;
      else u_set = 1;
    end else if (acc) begin
      m_q.push_back(x);
    end
    m_rdy = (m_q.size() == 0);
    m_sat = s_set || (m_sat && !clr);
    m_und = u_set || (m_und && !clr);
  endtask

  task automatic tick();
    last_acc = (sel != 0) ? (if2.in_valid && if2.in_ready) : (if1.in_valid && if1.in_ready);
    @(posedge clock);
    model_step(en, (sel != 0) ? if2.in_valid : if1.in_valid, clr_flags,
               (sel != 0) ? int'(if2.vin) : int'(if1.vin));
    #1;
    cyc++;
    chk("pwm",      (sel != 0) ? pwm2 : pwm1,             code(m_y));
    chk("in_ready", (sel != 0) ? if2.in_ready : if1.in_ready, m_rdy);
    chk("sat",      (sel != 0) ? sat2 : sat1,             m_sat);
    chk("underrun", (sel != 0) ? und2 : und1,             m_und);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    cyc = 0;
    #1;
    chk("rst_pwm",      (sel != 0) ? pwm2 : pwm1, 0);
    chk("rst_in_ready", (sel != 0) ? if2.in_ready : if1.in_ready, 0);
    chk("rst_sat",      (sel != 0) ? sat2 : sat1, 0);
    chk("rst_underrun", (sel != 0) ? und2 : und1, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Streams a constant on if1 from reset release; counts codes/accepts on edges 9..40.
  task automatic stream_window(input int x, output int np, output int nn, output int na);
    np = 0; nn = 0; na = 0;
    if1.in_valid = 1'b1;
    if1.vin = 15'(x);
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k >= 9) begin
        if (pwm1 == 2'b01) np++;
        if (pwm1 == 2'b11) nn++;
        if (last_acc) na++;
      end
    end
  endtask

  typedef struct {
    int vin;
    int n_pos;
    int n_neg;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int np, nn, na;
    bit got;
    tbl[0] = '{0,      0,  0};
    tbl[1] = '{8192,   16, 0};
    tbl[2] = '{-8192,  0,  16};
    tbl[3] = '{4096,   8,  0};
    tbl[4] = '{-4096,  0,  8};
    tbl[5] = '{12288,  24, 0};
    tbl[6] = '{16383,  32, 0};
    tbl[7] = '{-16384, 0,  32};

    if1.in_valid = 1'b0; if1.vin = '0;
    if2.in_valid = 1'b0; if2.vin = '0;
    en = 1'b1;
    #2;

    // DC table on the first-order instance.
    sel = 0;
    for (int i = 0; i < 8; i++) begin
      do_reset();
      stream_window(tbl[i].vin, np, nn, na);
      chk("tbl_pos", np, tbl[i].n_pos);
      chk("tbl_neg", nn, tbl[i].n_neg);
      chk("tbl_accepts", na, 4);
      if1.in_valid = 1'b0;
    end

    // Starvation after one -4096 sample, then flag clear and set-beats-clear.
    do_reset();
    if1.vin = -15'sd4096;
    if1.in_valid = 1'b1;
    tick(); tick();
    if1.in_valid = 1'b0;
    np = 0; nn = 0;
    for (int k = 3; k <= 48; k++) begin
      tick();
      if (k == 15) chk("starve_pre", und1, 0);
      if (k == 16) chk("starve_underrun", und1, 1);
      if (k >= 17 && pwm1 == 2'b11) nn++;
      if (k >= 17 && pwm1 == 2'b01) np++;
    end
    chk("starve_neg", nn, 8);
    chk("starve_pos", np, 0);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    chk("clr_underrun", und1, 0);
    repeat (6) tick();
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    chk("clr_vs_set", und1, 1);

    // Reset mid-run, then the half-scale pattern must reappear from scratch.
    do_reset();
    if1.vin = 15'sd8192;
    if1.in_valid = 1'b1;
    repeat (21) tick();
    chk("prerst_pwm", pwm1, 1);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    chk("midrst_pwm", pwm1, 0);
    chk("midrst_in_ready", if1.in_ready, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    cyc = 0;
    stream_window(8192, np, nn, na);
    chk("midrst_pos", np, 16);
    chk("midrst_neg", nn, 0);
    chk("midrst_accepts", na, 4);

    // Freeze with en=0 across would-be loads while accepts continue.
    en = 1'b0;
    repeat (12) tick();
    chk("en0_pwm", pwm1, 0);
    en = 1'b1;
    repeat (20) tick();
    if1.in_valid = 1'b0;

    // Second-order overflow with ACC_W = IN_W + 1.
    sel = 1;
    do_reset();
    if2.vin = 15'sd16383;
    if2.in_valid = 1'b1;
    got = 0;
    for (int k = 0; k < 8 + 4 * OSR && !got; k++) begin
      tick();
      if (sat2) got = 1;
    end
    chk("ovf_sat_within_4osr", got, 1);
    repeat (30) tick();
    if2.in_valid = 1'b0;

    // Random traffic on both instances.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      do_reset();
      for (int k = 0; k < 1500; k++) begin
        en = ($urandom_range(0, 9) != 0);
        clr_flags = ($urandom_range(0, 19) == 0);
        if (s == 0) begin
          if1.in_valid = ($urandom_range(0, 9) < 7);
          if1.vin = 15'($urandom_range(0, 32767));
        end else begin
          if2.in_valid = ($urandom_range(0, 9) < 7);
          if2.vin = 15'($urandom_range(0, 32767));
        end
        tick();
      end
      if1.in_valid = 1'b0;
      if2.in_valid = 1'b0;
      en = 1'b1;
      clr_flags = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
